// File: rtl/fpu_vector_sequencer_if.sv
// Handshake bundle between the vector sequencer (master) and one
// pfpu32_top instance (slave).
interface fpu_vector_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 8
);
   logic              fpu_flush;
   logic              fpu_decode;
   logic              fpu_execute;
   logic [OP_W-1:0]   fpu_op;
   logic [DATA_W-1:0] fpu_a;
   logic [DATA_W-1:0] fpu_b;
   logic [1:0]        fpu_rm;
   logic [DATA_W-1:0] fpu_result;
   logic              fpu_arith_valid;
   logic              fpu_cmp_flag;
   logic              fpu_cmp_valid;

   modport master (
      output fpu_flush, fpu_decode, fpu_execute,
      output fpu_op, fpu_a, fpu_b, fpu_rm,
      input  fpu_result, fpu_arith_valid,
      input  fpu_cmp_flag, fpu_cmp_valid
   );

   modport slave (
      input  fpu_flush, fpu_decode, fpu_execute,
      input  fpu_op, fpu_a, fpu_b, fpu_rm,
      output fpu_result, fpu_arith_valid,
      output fpu_cmp_flag, fpu_cmp_valid
   );
endinterface

// File: rtl/fpu_vector_sequencer.sv
// Vector table + issue engine: flushes the FPU, replays loaded vectors
// and reports each result or timeout on a one-cycle strobe.
module fpu_vector_sequencer #(
   parameter int DEPTH        = 16,
   parameter int DATA_W       = 32,
   parameter int OP_W         = 8,
   parameter int TIMEOUT      = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     load_valid,
   input  logic [OP_W-1:0]          load_op,
   input  logic [DATA_W-1:0]        load_a,
   input  logic [DATA_W-1:0]        load_b,
   input  logic [1:0]               load_rm,
   output logic                     load_ready,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_tests,
   output logic                     busy,
   output logic                     done,
   fpu_vector_sequencer_if.master   fpu,
   output logic                     res_valid,
   output logic [$clog2(DEPTH)-1:0] res_index,
   output logic [DATA_W-1:0]        res_data,
   output logic                     res_cmp_flag,
   output logic                     res_is_cmp,
   output logic                     res_timeout,
   output logic [CNT_W-1:0]         timeout_count,
   output logic [CNT_W-1:0]         issued_count
);
   localparam int IW = $clog2(DEPTH);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_DECODE, S_EXEC,
      S_WAIT, S_REPORT, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [IW:0]       fill_q, fill_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]  ntests_q, ntests_d;
   logic [CNT_W-1:0]  iss_q, iss_d;
   logic [CNT_W-1:0]  tmo_q, tmo_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic [WW-1:0]     wcnt_q, wcnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rflag_q, rflag_d;
   logic              riscmp_q, riscmp_d;
   logic              rtmo_q, rtmo_d;

   logic [OP_W-1:0]   op_mem [DEPTH];
   logic [DATA_W-1:0] a_mem  [DEPTH];
   logic [DATA_W-1:0] b_mem  [DEPTH];
   logic [1:0]        rm_mem [DEPTH];

   logic idle, load_en, active;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign idle       = (state_q == S_IDLE);
   assign load_ready = idle && (fill_q != (IW+1)'(DEPTH));
   assign load_en    = load_ready && load_valid && !clear;
   assign active     = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_WAIT);

   // Table storage carries no reset; only fill_q defines valid entries.
   always_ff @(posedge clk) begin
      if (load_en) begin
         op_mem[fill_q[IW-1:0]] <= load_op;
         a_mem[fill_q[IW-1:0]]  <= load_a;
         b_mem[fill_q[IW-1:0]]  <= load_b;
         rm_mem[fill_q[IW-1:0]] <= load_rm;
      end
   end

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      idx_d    = idx_q;
      ntests_d = ntests_q;
      iss_d    = iss_q;
      tmo_d    = tmo_q;
      fcnt_d   = fcnt_q;
      wcnt_d   = wcnt_q;
      rdata_d  = rdata_q;
      rflag_d  = rflag_q;
      riscmp_d = riscmp_q;
      rtmo_d   = rtmo_q;
      unique case (state_q)
         S_IDLE: begin
            if (clear) fill_d = '0;
            else if (load_en) fill_d = fill_q + (IW+1)'(1);
            if (start) begin
               if (fill_q == '0 || num_tests == '0) begin
                  state_d = S_DONE;
               end else begin
                  ntests_d = num_tests;
                  iss_d    = '0;
                  tmo_d    = '0;
                  idx_d    = '0;
                  fcnt_d   = FW'(1);
                  state_d  = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (fcnt_q == FW'(FLUSH_CYCLES)) state_d = S_DECODE;
            else fcnt_d = fcnt_q + FW'(1);
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            iss_d   = sat_inc(iss_q);
            wcnt_d  = WW'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Arith beats cmp, and any valid beats the timeout.
            if (fpu.fpu_arith_valid) begin
               rdata_d  = fpu.fpu_result;
               rflag_d  = 1'b0;
               riscmp_d = 1'b0;
               rtmo_d   = 1'b0;
               state_d  = S_REPORT;
            end else if (fpu.fpu_cmp_valid) begin
               rdata_d  = '0;
               rflag_d  = fpu.fpu_cmp_flag;
               riscmp_d = 1'b1;
               rtmo_d   = 1'b0;
               state_d  = S_REPORT;
            end else if (wcnt_q == WW'(TIMEOUT)) begin
               rdata_d  = '0;
               rflag_d  = 1'b0;
               riscmp_d = 1'b0;
               rtmo_d   = 1'b1;
               tmo_d    = sat_inc(tmo_q);
               state_d  = S_REPORT;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         S_REPORT: begin
            if (iss_q == ntests_q) begin
               state_d = S_DONE;
            end else begin
               idx_d = ({1'b0, idx_q} + (IW+1)'(1) == fill_q) ?
                       '0 : idx_q + IW'(1);
               state_d = S_DECODE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         fill_q   <= '0;
         idx_q    <= '0;
         ntests_q <= '0;
         iss_q    <= '0;
         tmo_q    <= '0;
         fcnt_q   <= '0;
         wcnt_q   <= '0;
         rdata_q  <= '0;
         rflag_q  <= 1'b0;
         riscmp_q <= 1'b0;
         rtmo_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         idx_q    <= idx_d;
         ntests_q <= ntests_d;
         iss_q    <= iss_d;
         tmo_q    <= tmo_d;
         fcnt_q   <= fcnt_d;
         wcnt_q   <= wcnt_d;
         rdata_q  <= rdata_d;
         rflag_q  <= rflag_d;
         riscmp_q <= riscmp_d;
         rtmo_q   <= rtmo_d;
      end
   end

   assign busy            = !idle;
   assign done            = (state_q == S_DONE);
   assign fpu.fpu_flush   = (state_q == S_FLUSH);
   assign fpu.fpu_decode  = (state_q == S_DECODE);
   assign fpu.fpu_execute = (state_q == S_EXEC);
   assign fpu.fpu_op      = active ? op_mem[idx_q] : '0;
   assign fpu.fpu_a       = active ? a_mem[idx_q]  : '0;
   assign fpu.fpu_b       = active ? b_mem[idx_q]  : '0;
   assign fpu.fpu_rm      = active ? rm_mem[idx_q] : '0;

   assign res_valid     = (state_q == S_REPORT);
   assign res_index     = idx_q;
   assign res_data      = rdata_q;
   assign res_cmp_flag  = rflag_q;
   assign res_is_cmp    = riscmp_q;
   assign res_timeout   = rtmo_q;
   assign timeout_count = tmo_q;
   assign issued_count  = iss_q;
endmodule

// File: tb/tb_fpu_vector_sequencer.sv
// Randomised bench for fpu_vector_sequencer: FPU responder driven by
// a per-issue plan, report checker derived from table and plan.
module tb_fpu_vector_sequencer;
   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;
   localparam int OP_W   = 8;
   localparam int TMO    = 3;
   localparam int FLC    = 2;
   localparam int CNT_W  = 16;
   localparam int IW     = 4;
   localparam int MAXN   = 64;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              clear = 1'b0;
   logic              load_valid = 1'b0;
   logic [OP_W-1:0]   load_op = '0;
   logic [DATA_W-1:0] load_a = '0;
   logic [DATA_W-1:0] load_b = '0;
   logic [1:0]        load_rm = '0;
   logic              load_ready;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  num_tests = '0;
   logic              busy, done, res_valid;
   logic [IW-1:0]     res_index;
   logic [DATA_W-1:0] res_data;
   logic              res_cmp_flag, res_is_cmp, res_timeout;
   logic [CNT_W-1:0]  timeout_count, issued_count;

   fpu_vector_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) fpu ();

   fpu_vector_sequencer #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W),
      .TIMEOUT(TMO), .FLUSH_CYCLES(FLC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .load_valid(load_valid), .load_op(load_op),
      .load_a(load_a), .load_b(load_b), .load_rm(load_rm),
      .load_ready(load_ready), .start(start),
      .num_tests(num_tests), .busy(busy), .done(done),
      .fpu(fpu), .res_valid(res_valid), .res_index(res_index),
      .res_data(res_data), .res_cmp_flag(res_cmp_flag),
      .res_is_cmp(res_is_cmp), .res_timeout(res_timeout),
      .timeout_count(timeout_count), .issued_count(issued_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [OP_W-1:0]   m_op [DEPTH];
   logic [DATA_W-1:0] m_a  [DEPTH];
   logic [DATA_W-1:0] m_b  [DEPTH];
   logic [1:0]        m_rm [DEPTH];
   int                m_fill = 0;

   // plat: 0 = FPU never answers, else latency after execute
   // pkind: 0 arith, 1 cmp only, 2 both valid
   int                plat  [MAXN];
   int                pkind [MAXN];
   logic [DATA_W-1:0] pval  [MAXN];
   bit                pflag [MAXN];

   int nrun = 0, issue = 0, rep = 0, mdone = 0;
   int fpu_act = 0, exp_tmo = 0, cyc = 0;
   bit zero_mode = 1'b0, spur_en = 1'b0;
   int exec_cyc [MAXN];
   int rn = 0, rcnt = 0, rwin = 0, rcur = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // FPU responder, following the plan for each issued vector
   initial forever begin
      @(posedge clk);
      #1;
      fpu.fpu_arith_valid = 1'b0;
      fpu.fpu_cmp_valid   = 1'b0;
      fpu.fpu_cmp_flag    = 1'b0;
      fpu.fpu_result      = '0;
      if (!reset_n) begin
         rcnt = 0;
         rwin = 0;
      end else begin
         if (rwin > 0) rwin--;
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               if (pkind[rcur] != 1) begin
                  fpu.fpu_arith_valid = 1'b1;
                  fpu.fpu_result      = pval[rcur];
               end
               if (pkind[rcur] == 1) begin
                  fpu.fpu_cmp_valid = 1'b1;
                  fpu.fpu_cmp_flag  = pflag[rcur];
               end
               if (pkind[rcur] == 2) begin
                  fpu.fpu_cmp_valid = 1'b1;
                  fpu.fpu_cmp_flag  = 1'b1;
               end
            end
         end
         if (fpu.fpu_execute) begin
            rcur = rn;
            rn++;
            rcnt = (rcur < MAXN) ? plat[rcur] : 0;
            rwin = TMO + 1;
         end else if (spur_en && rwin == 0 &&
                      $urandom_range(0, 3) == 0) begin
            fpu.fpu_arith_valid = 1'($urandom);
            fpu.fpu_cmp_valid   = 1'b1;
            fpu.fpu_cmp_flag    = 1'b1;
            fpu.fpu_result      = $urandom;
         end
      end
   end

   // Report checker
   initial begin : mon
      int e, lat;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (fpu.fpu_flush || fpu.fpu_decode || fpu.fpu_execute)
               fpu_act++;
            if (fpu.fpu_execute) begin
               e = (m_fill == 0) ? 0 : issue % m_fill;
               chk("issue_in_range", 64'(issue < nrun), 1);
               if (issue < MAXN) exec_cyc[issue] = cyc;
               chk("fpu_op", fpu.fpu_op, m_op[e]);
               chk("fpu_a", fpu.fpu_a, m_a[e]);
               chk("fpu_b", fpu.fpu_b, m_b[e]);
               chk("fpu_rm", fpu.fpu_rm, m_rm[e]);
               issue++;
            end
            if (res_valid) begin
               chk("res_expected", 64'(rep < issue), 1);
               if (rep < issue && rep < MAXN && m_fill > 0) begin
                  lat = (plat[rep] == 0) ? TMO : plat[rep];
                  chk("res_index", res_index, rep % m_fill);
                  chk("res_timing", cyc, exec_cyc[rep] + lat + 1);
                  chk("res_timeout", res_timeout, plat[rep] == 0);
                  if (plat[rep] == 0) begin
                     chk("res_data_tmo", res_data, 0);
                  end else if (pkind[rep] != 1) begin
                     chk("res_is_cmp_arith", res_is_cmp, 0);
                     chk("res_data", res_data, pval[rep]);
                  end else begin
                     chk("res_is_cmp_cmp", res_is_cmp, 1);
                     chk("res_cmp_flag", res_cmp_flag, pflag[rep]);
                  end
               end
               rep++;
            end
            if (done) begin
               mdone++;
               if (!zero_mode) begin
                  chk("issued_count", issued_count, nrun);
                  chk("timeout_count", timeout_count, exp_tmo);
                  chk("reports_at_done", rep, nrun);
               end
            end
         end
      end
   end

   task automatic chk_reset_vals(string tag);
      chk({tag, "_load_ready"}, load_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_fpu_ctl"},
          {fpu.fpu_flush, fpu.fpu_decode, fpu.fpu_execute}, 0);
      chk({tag, "_fpu_opnd"},
          {fpu.fpu_op, fpu.fpu_a, fpu.fpu_rm}, 0);
      chk({tag, "_res"},
          {res_index, res_cmp_flag, res_is_cmp, res_timeout}, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_counts"}, {timeout_count, issued_count}, 0);
   endtask

   task automatic do_load(logic [OP_W-1:0] op, logic [31:0] a,
                          logic [31:0] b, logic [1:0] rm);
      chk("load_ready", load_ready, 64'(m_fill < DEPTH));
      load_valid = 1'b1;
      load_op = op;
      load_a  = a;
      load_b  = b;
      load_rm = rm;
      tick;
      load_valid = 1'b0;
      if (m_fill < DEPTH) begin
         m_op[m_fill] = op;
         m_a[m_fill]  = a;
         m_b[m_fill]  = b;
         m_rm[m_fill] = rm;
         m_fill++;
      end
   endtask

   task automatic rand_load;
      do_load(OP_W'($urandom), $urandom, $urandom, 2'($urandom));
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick;
      clear = 1'b0;
      m_fill = 0;
   endtask

   task automatic rand_plan(int n, bit allow_tmo);
      for (int r = 0; r < n; r++) begin
         plat[r]  = allow_tmo ? $urandom_range(0, TMO) :
                                $urandom_range(1, TMO);
         pkind[r] = $urandom_range(0, 2);
         pval[r]  = $urandom;
         pflag[r] = 1'($urandom);
      end
   endtask

   task automatic run(int n);
      nrun = n;
      issue = 0;
      rep = 0;
      mdone = 0;
      rn = 0;
      zero_mode = 1'b0;
      exp_tmo = 0;
      for (int r = 0; r < n; r++) if (plat[r] == 0) exp_tmo++;
      start = 1'b1;
      num_tests = CNT_W'(n);
      tick;
      start = 1'b0;
      num_tests = CNT_W'($urandom);
      for (int f = 0; f < FLC; f++) begin
         chk("flush_busy", busy, 1);
         chk("flush_on", fpu.fpu_flush, 1);
         chk("flush_no_dec", fpu.fpu_decode, 0);
         tick;
      end
      chk("decode_on", fpu.fpu_decode, 1);
      chk("decode_no_flush", fpu.fpu_flush, 0);
      tick;
      chk("execute_on", fpu.fpu_execute, 1);
      for (int i = 0; i < n * (TMO + 4) + 10; i++) begin
         if (mdone > 0) break;
         tick;
      end
      tick;
      chk("done_once", mdone, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("reports", rep, n);
      chk("issues", issue, n);
   endtask

   task automatic run_zero(int n);
      int act0;
      zero_mode = 1'b1;
      mdone = 0;
      act0 = fpu_act;
      start = 1'b1;
      num_tests = CNT_W'(n);
      tick;
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      chk("zero_flush", fpu.fpu_flush, 0);
      tick;
      chk("zero_done_end", done, 0);
      chk("zero_idle", busy, 0);
      tick;
      tick;
      chk("zero_no_fpu", fpu_act, act0);
      chk("zero_done_cnt", mdone, 1);
      zero_mode = 1'b0;
   endtask

   initial begin
      fpu.fpu_arith_valid = 1'b0;
      fpu.fpu_cmp_valid = 1'b0;
      fpu.fpu_cmp_flag = 1'b0;
      fpu.fpu_result = '0;
      repeat (3) tick;
      chk_reset_vals("in_reset");
      reset_n = 1'b1;
      tick;
      chk_reset_vals("after_reset");

      run_zero(1);

      do_load(8'h00, 32'h3F800000, 32'h40000000, 2'd0);
      plat[0] = 2;
      pkind[0] = 0;
      pval[0] = 32'h40400000;
      pflag[0] = 1'b0;
      run(1);
      chk("single_res_data", res_data, 32'h40400000);
      chk("single_issued", issued_count, 1);

      run_zero(0);

      clear = 1'b1;
      load_valid = 1'b1;
      tick;
      clear = 1'b0;
      load_valid = 1'b0;
      m_fill = 0;
      run_zero(1);

      repeat (3) rand_load;
      rand_plan(7, 1'b1);
      run(7);
      chk("fill_kept_ready", load_ready, 1);
      rand_plan(3, 1'b0);
      run(3);

      for (int r = 0; r < 4; r++) plat[r] = 0;
      run(4);
      chk("all_tmo_count", timeout_count, 4);

      plat[0] = 1; pkind[0] = 2; pval[0] = 32'hC0A00000;
      plat[1] = TMO; pkind[1] = 1; pflag[1] = 1'b1;
      run(2);

      spur_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         do_clear;
         repeat ($urandom_range(1, DEPTH)) rand_load;
         rand_plan(int'($urandom_range(1, 20)), 1'b1);
         run(int'($urandom_range(1, 20)));
      end
      spur_en = 1'b0;

      do_clear;
      repeat (DEPTH) rand_load;
      chk("full_not_ready", load_ready, 0);
      do_load(8'hAA, 32'h1, 32'h2, 2'd3);
      rand_plan(17, 1'b1);
      run(17);

      for (int r = 0; r < 3; r++) plat[r] = 0;
      nrun = 3; issue = 0; rep = 0; mdone = 0; rn = 0;
      start = 1'b1;
      num_tests = 3;
      tick;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (issue > 0) break;
         tick;
      end
      chk("abort_exec_seen", 64'(issue > 0), 1);
      reset_n = 1'b0;
      #2;
      chk_reset_vals("abort");
      tick;
      reset_n = 1'b1;
      m_fill = 0;
      repeat (6) tick;
      chk("abort_no_done", mdone, 0);
      chk("abort_no_res", rep, 0);
      run_zero(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
